spi_regbank: RTL

Parametrised SPI register-bank peripheral, the successor to the single-frame write-only SPI receiver. It owns NUM_REGS writable and readable configuration registers of DATA_W bits each. These sit between an external SPI controller (mode 0) and the PWM/control logic that consumes them. Unlike its predecessor it supports read-back on CIPO, validates frame length and address, and reports per-write strobes and errors.

---
 rtl/spi_regbank.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/spi_regbank.sv
// SPI (mode 0) register-bank peripheral. Frames are R/W, address and data,
// MSB first. Writes commit on nCS rise; reads shift register contents on CIPO.
module spi_regbank #(
  parameter int NUM_REGS = 5,
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sclk,
  input  logic                         COPI,
  input  logic                         nCS,
  output logic                         CIPO,
  output logic                         CIPO_oe,
  output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
  output logic                         wr_strobe,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic                         frame_err
);

  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 2);
  localparam int IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int SH_W    = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

  logic [2:0]        r_sclk_sync;
  logic [2:0]        r_ncs_sync;
  logic [1:0]        r_copi_sync;
  logic [1:0]        r_sync_vld;
  logic              r_armed;
  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [SH_W-1:0]   r_shift_in;
  logic              r_rw;
  logic [ADDR_W-1:0] r_addr;
  logic              r_addr_ok;
  logic [DATA_W-1:0] r_shift_out;
  logic              r_cipo;
  logic [DATA_W-1:0] r_regs [NUM_REGS];

  logic              w_sclk_rise, w_sclk_fall, w_ncs_rise, w_ncs_fall, w_copi;
  logic [ADDR_W:0]   w_hdr;
  logic [ADDR_W-1:0] w_hdr_addr;
  logic              w_hdr_ok;
  logic [IDX_W-1:0]  w_rd_idx, w_wr_idx;
  logic              w_last_addr_bit, w_last_data_bit;
  logic              w_start, w_shift, w_hdr_done, w_end, w_valid;
  logic              w_commit_wr, w_commit_err, w_cipo_active, w_cipo_shift;

  // Bring the SPI pins into the clk domain and arm once nCS is seen high.
  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, exactly like real hardware.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_sync <= '0;
      r_ncs_sync  <= '1;
      r_copi_sync <= '0;
      r_sync_vld  <= '0;
      r_armed     <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[1:0], sclk};
      r_ncs_sync  <= {r_ncs_sync[1:0], nCS};
      r_copi_sync <= {r_copi_sync[0], COPI};
      r_sync_vld  <= {r_sync_vld[0], 1'b1};
      // A frame already running when reset ends is skipped: the chain must
      // carry a real high nCS sample before any falling edge is accepted.
      if (r_sync_vld[1] && r_ncs_sync[1]) r_armed <= 1'b1;
    end
  end

  assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_sync[2];
  assign w_sclk_fall = ~r_sclk_sync[1] & r_sclk_sync[2];
  assign w_ncs_rise  = r_ncs_sync[1] & ~r_ncs_sync[2];
  assign w_ncs_fall  = ~r_ncs_sync[1] & r_ncs_sync[2];
  assign w_copi      = r_copi_sync[1];

  assign w_hdr           = {r_shift_in[ADDR_W-1:0], w_copi};
  assign w_hdr_addr      = w_hdr[ADDR_W-1:0];
  assign w_hdr_ok        = int'(w_hdr_addr) < NUM_REGS;
  assign w_rd_idx        = w_hdr_addr[IDX_W-1:0];
  assign w_wr_idx        = r_addr[IDX_W-1:0];
  assign w_last_addr_bit = (r_bit_cnt == CNT_W'(ADDR_W));
  assign w_last_data_bit = (r_bit_cnt == CNT_W'(FRAME_W - 1));

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next state; an nCS rise ends any frame in progress.
  // NOTE: the default assignment up front keeps this purely combinational;
  // a path that left w_state_nxt unassigned would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_ncs_fall && r_armed)            w_state_nxt = S_ADDR;
      S_ADDR:  if (w_sclk_rise && w_last_addr_bit)   w_state_nxt = S_DATA;
      S_DATA:  if (w_sclk_rise && w_last_data_bit)   w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (r_state != S_IDLE && w_ncs_rise) w_state_nxt = S_IDLE;
  end

  // FSM outputs: datapath controls derived from state and synchronised edges.
  always_comb begin
    w_start       = (r_state == S_IDLE) && w_ncs_fall && r_armed;
    w_shift       = (r_state != S_IDLE) && w_sclk_rise;
    w_hdr_done    = (r_state == S_ADDR) && w_sclk_rise && w_last_addr_bit;
    w_end         = (r_state != S_IDLE) && w_ncs_rise;
    w_valid       = (r_bit_cnt == CNT_W'(FRAME_W)) && r_addr_ok;
    w_commit_wr   = w_end && w_valid && r_rw;
    w_commit_err  = w_end && !w_valid;
    w_cipo_active = (r_state == S_DATA) && !r_rw;
    w_cipo_shift  = w_cipo_active && w_sclk_fall;
  end

  // Frame datapath: bit counter, input shifter, header latch and read shifter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_cnt   <= '0;
      r_shift_in  <= '0;
      r_rw        <= 1'b0;
      r_addr      <= '0;
      r_addr_ok   <= 1'b0;
      r_shift_out <= '0;
      r_cipo      <= 1'b0;
    end else begin
      if (w_start) begin
        r_bit_cnt  <= '0;
        r_shift_in <= '0;
        r_rw       <= 1'b0;
        r_addr     <= '0;
        r_addr_ok  <= 1'b0;
      end else if (w_shift) begin
        r_shift_in <= {r_shift_in[SH_W-2:0], w_copi};
        // Saturating one past a full frame marks an overlength frame.
        if (r_bit_cnt != CNT_W'(FRAME_W + 1)) r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      end
      if (w_hdr_done) begin
        r_rw        <= w_hdr[ADDR_W];
        r_addr      <= w_hdr_addr;
        r_addr_ok   <= w_hdr_ok;
        r_shift_out <= w_hdr_ok ? r_regs[w_rd_idx] : '0;
      end else if (w_cipo_shift) begin
        r_shift_out <= r_shift_out << 1;
      end
      if (!w_cipo_active)   r_cipo <= 1'b0;
      else if (w_cipo_shift) r_cipo <= r_shift_out[DATA_W-1];
    end
  end

  // Register file and commit reporting.
  // NOTE: the bank is a handful of flops feeding live control logic, so it is
  // reset explicitly; a RAM-style array would instead be left unreset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
      wr_addr   <= '0;
    end else begin
      wr_strobe <= w_commit_wr;
      frame_err <= w_commit_err;
      if (w_commit_wr) begin
        r_regs[w_wr_idx] <= r_shift_in[DATA_W-1:0];
        wr_addr          <= r_addr;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
    assign regs_flat[gi*DATA_W +: DATA_W] = r_regs[gi];
  end

  assign CIPO    = r_cipo;
  assign CIPO_oe = ~r_ncs_sync[1];

endmodule
